// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 4;
  localparam int NUM_RD_DEF  = 2;
  localparam int CNT_W_DEF   = 2;
  localparam int CNT_SAT_DEF = (1 << CNT_W_DEF) - 1;

  // Net effect of one clock edge on a pending-write counter
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/rf_entry.sv
// One architectural register: data word plus its pending-write counter.
// The parent decides whether a reservation is granted; this entry only
// applies the granted reservation and the write strobe.
module rf_entry
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              sat,
  output logic              empty
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  cnt_op_e          op;

  // Choose counter action: a write and a reservation in the same edge cancel
  always_comb begin
    op = CNT_HOLD;
    if (rsv && !wr) begin
      op = CNT_INC;
    end else if (wr && !rsv && (cnt != '0)) begin
      op = CNT_DEC;
    end
  end

  // Next counter value, also exported (as busy) for early release to readers
  always_comb begin
    cnt_next = cnt;
    case (op)
      CNT_INC: cnt_next = cnt + 1'b1;
      CNT_DEC: cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  end

  assign sat   = (cnt == {CNT_W{1'b1}});
  assign empty = (cnt == '0);
  // While held in reset the next state is necessarily zero
  assign busy  = rst && (cnt_next != '0);

  // Data and counter state, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        data <= wr_data;
      end
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard, write-to-read
// bypass and a sticky error flag for writes nobody reserved.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic                     wr_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   reg_data [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] sat_vec;
  logic [NUM_REGS-1:0] empty_vec;
  logic                wr_act;
  logic                rsv_act;

  // Register 0 is hard-wired: reads zero, never pending, never saturated
  assign reg_data[0]  = '0;
  assign busy_vec[0]  = 1'b0;
  assign sat_vec[0]   = 1'b0;
  assign empty_vec[0] = 1'b1;

  assign wr_act = wr_en && (wr_addr != '0);

  // A saturated counter can still accept a reservation when a write to the
  // same register retires in the same edge, because the two cancel out.
  assign rsv_ok  = (rsv_addr == '0) || !sat_vec[rsv_addr] ||
                   (wr_en && (wr_addr == rsv_addr));
  assign rsv_act = rsv_en && rsv_ok && (rsv_addr != '0);

  generate
    for (genvar k = 1; k < NUM_REGS; k++) begin : g_ent
      logic wr_hit;
      logic rsv_hit;

      assign wr_hit  = wr_act  && (wr_addr  == ADDR_W'(k));
      assign rsv_hit = rsv_act && (rsv_addr == ADDR_W'(k));

      rf_entry #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_ent (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr_hit),
        .wr_data (wr_data),
        .rsv     (rsv_hit),
        .data    (reg_data[k]),
        .busy    (busy_vec[k]),
        .sat     (sat_vec[k]),
        .empty   (empty_vec[k])
      );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;

      assign ra = rd_addr[i*ADDR_W +: ADDR_W];
      assign rd_data[i*DATA_W +: DATA_W] =
        (wr_act && (ra == wr_addr)) ? wr_data : reg_data[ra];
      assign rd_busy[i] = busy_vec[ra];
    end
  endgenerate

  // Sticky error: a write retired into a register with nothing pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
    end else if (wr_act && empty_vec[wr_addr]) begin
      wr_err <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register index width; NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter CNT_W, default 2, meaning pending-write counter width per register.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read indices; port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, combinational.
REQ-009 SHALL have port rd_busy  output  NUM_RD  per-port flag: the addressed register still has pending writes.
REQ-010 SHALL have port wr_en  input  1  write strobe.
REQ-011 SHALL have port wr_addr  input  ADDR_W  write index.
REQ-012 SHALL have port wr_data  input  DATA_W  write data.
REQ-013 SHALL have port rsv_en  input  1  reservation request (issue of an instruction targeting rsv_addr).
REQ-014 SHALL have port rsv_addr  input  ADDR_W  reservation index.
REQ-015 SHALL have port rsv_ok  output  1  combinational grant for the current rsv_en.
REQ-016 SHALL have port wr_err  output  1  sticky flag: a write hit a register with zero pending count.

Function
REQ-017 Register 0 SHALL always read 0; writes to it are discarded; its counter stays 0; reservations of it are granted (rsv_ok=1) with no state change.
REQ-018 Write: on a rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data.
REQ-019 Read bypass: if wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, rd_data[i] SHALL equal wr_data in that same cycle; otherwise it equals reg[rd_addr[i]].
REQ-020 Each register 1..NUM_REGS-1 SHALL own an unsigned CNT_W-bit pending counter, cnt.
REQ-021 rsv_ok SHALL be 1 when rsv_addr==0, or when cnt[rsv_addr] < 2**CNT_W-1, or when that counter is saturated and a write to the same index occurs in the same cycle; otherwise 0.
REQ-022 Counter update per edge: granted reservation alone -> +1; write alone with cnt>0 -> -1; granted reservation and write to the same index -> unchanged; refused reservation -> no reservation effect.
REQ-023 A write to a nonzero index with cnt==0 SHALL still update data, leave cnt at 0, and set wr_err=1 on that edge; wr_err then holds until reset.
REQ-024 rd_busy[i] SHALL be 1 iff the next-state counter of rd_addr[i] (per REQ-022) is nonzero; rd_busy for index 0 is always 0.
REQ-025 Reservation and write to different indices in the same cycle SHALL update both counters independently.
REQ-026 Read ports SHALL be fully independent; any number of ports may address the same register.

Reset
REQ-027 While rst=0, all registers, all counters and wr_err SHALL clear to 0 asynchronously; rd_data then reads 0, rd_busy reads 0 unless bypass applies, and rsv_ok reads 1.
REQ-028 An edge on which rst is low SHALL discard the write, the reservation and the error update.
REQ-029 After rst deasserts, the first rising clk edge SHALL operate normally.

Structure
REQ-030 Package regfile_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD/CNT_W constants and the counter-saturation constant.
REQ-031 One sub-module, rf_entry (data register plus pending counter, write/reserve inputs, busy/saturated outputs), SHALL be instantiated for indices 1..NUM_REGS-1 by generate; index 0 is a constant.

Verification
REQ-032 Reset then write R3=16'hBEEF, read R3 on port0 the next cycle -> rd_data0=BEEF, wr_err=1 (unreserved write).
REQ-033 Bypass: wr_en R5=16'h1234 while rd_addr0=5 and rd_addr1=5 in the same cycle -> both ports read 1234 combinationally.
REQ-034 Reserve R7 three times (CNT_W=2) -> rsv_ok=1 each time, rd_busy=1; fourth reservation -> rsv_ok=0; fourth reservation together with a write to R7 -> rsv_ok=1, cnt stays 3.
REQ-035 Drain: three writes to R7 -> rd_busy drops to 0 in the cycle of the third write (early), wr_err remains 0.
REQ-036 R0: write 16'hFFFF to R0, reserve R0 -> rd_data=0, rsv_ok=1, rd_busy=0, wr_err unchanged.
REQ-037 Assert rst low mid-sequence with R2 reserved and written -> rd_data=0, rd_busy=0, wr_err=0 immediately; the edge coincident with rst low has no effect.
